// File: rtl/clint_pkg.sv
// Shared constants, size encodings and FSM state type for the CLINT MMIO bridge.
package clint_pkg;

  localparam logic [63:0] CLINT_BASE_DEF = 64'h200_0000;
  localparam logic [63:0] CLINT_SIZE_DEF = 64'h1_0000;
  localparam logic [63:0] ADDR_MTIMECMP  = 64'h200_4000;
  localparam logic [63:0] ADDR_MTIME     = 64'h200_BFF8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Natural alignment: the low size address bits must all be zero.
  function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo[1:0];
      default: bad = |lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/clint_mmio_bridge_if.sv
// MEM-side request/response channels plus the CLINT dword strobe bus.
interface clint_mmio_bridge_if;

  // Handshakes: a beat transfers on the rising clk edge where valid & ready are
  // both high; valid never waits on ready, and the payload is held stable while
  // valid is high and ready is low.
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  logic [63:0] clint_addr;
  logic [63:0] clint_wr_data;
  logic        clint_wen;
  logic        clint_ren;
  logic [63:0] clint_rd_data;

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
    input  resp_ready, clint_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output clint_addr, clint_wr_data, clint_wen, clint_ren
  );

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
    output resp_ready, clint_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  clint_addr, clint_wr_data, clint_wen, clint_ren
  );

endinterface

// File: rtl/clint_lane_align.sv
// Combinational byte-lane helper: extracts/extends load data and merges store
// bytes into an old dword, both steered by the byte offset within the dword.
module clint_lane_align
  import clint_pkg::*;
(
  input  logic [63:0] old_data,
  input  logic [63:0] wdata,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] load_data,
  output logic [63:0] merge_data
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;

  assign shamt = {offset, 3'b000};

  always_comb begin
    shifted    = old_data >> shamt;
    size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
    load_data  = shifted;
    case (size)
      SZ_B: begin
        size_mask = 64'h0000_0000_0000_00FF;
        load_data = is_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        load_data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        load_data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: ;
    endcase
    lane_mask  = size_mask << shamt;
    merge_data = (old_data & ~lane_mask) | ((wdata & size_mask) << shamt);
  end

endmodule

// File: rtl/clint_mmio_bridge.sv
// MEM-stage initiator for the CLINT timer window: window/alignment check, dword
// read/write strobes with read-modify-write for sub-dword stores, held response.
module clint_mmio_bridge
  import clint_pkg::*;
#(
  parameter logic [63:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [63:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  clint_mmio_bridge_if.slave  bus,
  output state_t              dbg_state
);

  state_t      state, state_next;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        wen_q;
  logic [63:0] data_q;   // store data until RD, then the merged dword for WR
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        in_window;
  logic        req_err;
  logic [64:0] addr_ext;
  logic [64:0] win_lo;
  logic [64:0] win_hi;
  logic [63:0] load_data;
  logic [63:0] merge_data;

  // 65-bit bounds so a window near the top of the address space cannot wrap.
  assign addr_ext  = {1'b0, bus.req_addr};
  assign win_lo    = {1'b0, CLINT_BASE};
  assign win_hi    = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
  assign in_window = (addr_ext >= win_lo) && (addr_ext < win_hi);
  assign req_err   = !in_window || is_misaligned(bus.req_addr[2:0], bus.req_size);
  assign accept    = bus.req_valid && (state == IDLE);

  clint_lane_align u_lane_align (
    .old_data    (bus.clint_rd_data),
    .wdata       (data_q),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next        = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = 64'd0;
    bus.resp_err      = 1'b0;
    bus.clint_addr    = 64'd0;
    bus.clint_wr_data = 64'd0;
    bus.clint_wen     = 1'b0;
    bus.clint_ren     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                                  state_next = RESP;
          else if (bus.req_wen && bus.req_size == SZ_D) state_next = WR;
          else                                          state_next = RD;
        end
      end
      RD:      state_next = wen_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Every output is forced low while reset is asserted, whatever the state.
    if (rst_n) begin
      case (state)
        IDLE: bus.req_ready = 1'b1;
        RD: begin
          bus.clint_ren  = 1'b1;
          bus.clint_addr = {addr_q[63:3], 3'b000};
        end
        WR: begin
          bus.clint_wen     = 1'b1;
          bus.clint_addr    = {addr_q[63:3], 3'b000};
          bus.clint_wr_data = data_q;
        end
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = rdata_q;
          bus.resp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= 64'd0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            wen_q   <= bus.req_wen;
            data_q  <= bus.req_wdata;
            rdata_q <= 64'd0;
            err_q   <= req_err;
          end
        end
        RD: begin
          if (wen_q) data_q  <= merge_data;
          else       rdata_q <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = rst_n ? state : IDLE;

endmodule

// File: tb/tb_clint_mmio_bridge.sv
// Directed bench for clint_mmio_bridge: byte-level CLINT model, cycle-stamped
// strobe/response expectations, and literal pins on key results.
module tb_clint_mmio_bridge;
  import clint_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clint_mmio_bridge_if bus ();

  clint_mmio_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- CLINT responder (environment) ----------------
  logic [63:0] rsp_cmp = 64'd0;
  logic [63:0] rsp_time = 64'd0;

  always_comb begin
    bus.clint_rd_data = 64'd0;
    if (bus.clint_ren) begin
      if (bus.clint_addr == ADDR_MTIMECMP)   bus.clint_rd_data = rsp_cmp;
      else if (bus.clint_addr == ADDR_MTIME) bus.clint_rd_data = rsp_time;
    end
  end

  always @(posedge clk) begin
    if (bus.clint_wen) begin
      if (bus.clint_addr == ADDR_MTIMECMP)   rsp_cmp  <= bus.clint_wr_data;
      else if (bus.clint_addr == ADDR_MTIME) rsp_time <= bus.clint_wr_data;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [63:0] data;
    int          at_cyc;
  } strb_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  strb_t exp_strb_q[$];
  resp_t exp_resp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic [63:0] last_wdata = 64'd0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Byte-addressed model of the two timer registers; everything else reads 0.
  logic [7:0] m_cmp  [8] = '{default: 8'h00};
  logic [7:0] m_time [8] = '{default: 8'h00};

  function automatic logic [7:0] m_get(input logic [63:0] a);
    logic [63:0] base = a - (a % 64'd8);
    int          idx  = int'(a % 64'd8);
    if (base == ADDR_MTIMECMP) return m_cmp[idx];
    if (base == ADDR_MTIME)    return m_time[idx];
    return 8'h00;
  endfunction

  function automatic void m_set(input logic [63:0] a, input logic [7:0] v);
    logic [63:0] base = a - (a % 64'd8);
    int          idx  = int'(a % 64'd8);
    if (base == ADDR_MTIMECMP) m_cmp[idx] = v;
    else if (base == ADDR_MTIME) m_time[idx] = v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready",  64'(bus.req_ready),  64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_rdata", bus.resp_rdata,      64'd0);
      chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
      chk("rst_clint_addr", bus.clint_addr,      64'd0);
      chk("rst_clint_wdat", bus.clint_wr_data,   64'd0);
      chk("rst_strobes",    64'({bus.clint_wen, bus.clint_ren}), 64'd0);
    end else begin
      if (bus.clint_ren && bus.clint_wen) fail("strobe_overlap");
      if (bus.clint_ren || bus.clint_wen) begin
        if (exp_strb_q.size() == 0) begin
          fail("stray_strobe");
        end else begin
          strb_t e;
          e = exp_strb_q.pop_front();
          chk("strobe_kind",  64'(bus.clint_wen), 64'(e.is_wr));
          chk("strobe_addr",  bus.clint_addr,     e.addr);
          chk("strobe_cycle", 64'(cyc),           64'(e.at_cyc));
          if (e.is_wr) chk("strobe_wdata", bus.clint_wr_data, e.data);
        end
        if (bus.clint_wen) last_wdata = bus.clint_wr_data;
      end else begin
        chk("idle_clint_addr", bus.clint_addr,    64'd0);
        chk("idle_clint_wdat", bus.clint_wr_data, 64'd0);
      end
      if (bus.resp_valid) begin
        chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
        if (exp_resp_q.size() == 0) begin
          fail("stray_resp");
        end else begin
          chk("resp_rdata", bus.resp_rdata,      exp_resp_q[0].rdata);
          chk("resp_err",   64'(bus.resp_err),   64'(exp_resp_q[0].err));
          if (bus.resp_ready) void'(exp_resp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the bridge idle; returns at posedge+1 after the
  // response handshake edge.
  task automatic do_req(input bit wen, input logic [1:0] size, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input int hold, output logic [63:0] got_rdata, output logic got_err);
    int          n = 1 << size;
    logic [64:0] top = {1'b0, CLINT_BASE_DEF} + {1'b0, CLINT_SIZE_DEF};
    logic [63:0] base = addr - (addr % 64'd8);
    bit          err;
    logic [63:0] exp_rd = 64'd0;
    logic [63:0] new_dw = 64'd0;
    int          exp_lat;
    int          acc;
    int          lat = 0;
    bit          ok = 0;
    strb_t       s;
    resp_t       r;

    got_rdata = 64'd0;
    got_err   = 1'b0;
    err = (addr < CLINT_BASE_DEF) || ({1'b0, addr} >= top) || ((addr % 64'(n)) != 64'd0);

    bus.req_valid    = 1'b1;
    bus.req_wen      = wen;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      fail("req_ready_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.req_valid = 1'b0;

    if (err) begin
      exp_lat = 1;
    end else if (!wen) begin
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = m_get(addr + 64'(i));
      if (!uns && n < 8 && exp_rd[8*n-1]) exp_rd = exp_rd - (64'd1 << (8*n));
      exp_lat = 2;
      s = '{is_wr: 1'b0, addr: base, data: 64'd0, at_cyc: acc};
      exp_strb_q.push_back(s);
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [63:0] ba = base + 64'(i);
        if (ba >= addr && ba < addr + 64'(n)) new_dw[8*i +: 8] = wdata[8*int'(ba - addr) +: 8];
        else                                  new_dw[8*i +: 8] = m_get(ba);
      end
      for (int i = 0; i < 8; i++) m_set(base + 64'(i), new_dw[8*i +: 8]);
      if (n == 8) begin
        exp_lat = 2;
        s = '{is_wr: 1'b1, addr: base, data: new_dw, at_cyc: acc};
        exp_strb_q.push_back(s);
      end else begin
        exp_lat = 3;
        s = '{is_wr: 1'b0, addr: base, data: 64'd0, at_cyc: acc};
        exp_strb_q.push_back(s);
        s = '{is_wr: 1'b1, addr: base, data: new_dw, at_cyc: acc + 1};
        exp_strb_q.push_back(s);
      end
    end
    r = '{rdata: exp_rd, err: err};
    exp_resp_q.push_back(r);

    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin ok = 1; lat = cyc - acc + 1; break; end
    end
    if (!ok) begin
      fail("resp_valid_timeout");
      exp_resp_q.delete();
      exp_strb_q.delete();
      return;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    chk("strobes_drained", 64'(exp_strb_q.size()), 64'd0);
    chk("resp_drained",    64'(exp_resp_q.size()), 64'd0);
  endtask

  // Accept a load, then assert reset during its RD cycle; nothing may follow.
  task automatic do_reset_in_rd(input logic [63:0] addr);
    bit ok = 0;
    bus.req_valid    = 1'b1;
    bus.req_wen      = 1'b0;
    bus.req_size     = SZ_D;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = addr;
    bus.req_wdata    = 64'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      fail("req_ready_timeout_rst");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("in_rd_before_rst", 64'(dbg_state), 64'(RD));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_state",      64'(dbg_state),      64'(IDLE));
      chk("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("post_rst_req_ready",  64'(bus.req_ready),  64'd1);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [63:0] rd;
    logic        er;
    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'd0;
    bus.req_wdata    = 64'd0;
    bus.resp_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state",     64'(dbg_state),      64'(IDLE));
    chk("reset_req_ready", 64'(bus.req_ready),  64'd1);
    chk("reset_resp",      64'(bus.resp_valid), 64'd0);
    @(posedge clk);
    #1;

    // dword load, dword store + readback
    do_req(1'b0, SZ_D, 1'b0, 64'h200_4000, 64'd0, 0, rd, er);
    chk("lit_ld_init", rd, 64'd0);
    do_req(1'b1, SZ_D, 1'b0, 64'h200_4000, 64'h1234, 0, rd, er);
    chk("lit_sd_wdata", last_wdata, 64'h1234);
    do_req(1'b0, SZ_D, 1'b0, 64'h200_4000, 64'd0, 0, rd, er);
    chk("lit_ld_1234", rd, 64'h1234);

    // sub-dword byte store merges into the old value
    do_req(1'b1, SZ_D, 1'b0, 64'h200_4000, 64'h1122_3344_5566_7788, 0, rd, er);
    do_req(1'b1, SZ_B, 1'b0, 64'h200_4003, 64'hAB, 0, rd, er);
    chk("lit_sb_merge", last_wdata, 64'h1122_3344_AB66_7788);

    // sign vs zero extension of a word load
    do_req(1'b1, SZ_D, 1'b0, 64'h200_4000, 64'h8000_0000_0000_0000, 0, rd, er);
    do_req(1'b0, SZ_W, 1'b0, 64'h200_4004, 64'd0, 0, rd, er);
    chk("lit_lw", rd, 64'hFFFF_FFFF_8000_0000);
    do_req(1'b0, SZ_W, 1'b1, 64'h200_4004, 64'd0, 0, rd, er);
    chk("lit_lwu", rd, 64'h0000_0000_8000_0000);

    // errors: misaligned, outside window, window edges, wrap-around candidate
    do_req(1'b0, SZ_H, 1'b0, 64'h200_4001, 64'd0, 0, rd, er);
    chk("lit_lh_mis_err", 64'(er), 64'd1);
    do_req(1'b0, SZ_D, 1'b0, 64'h300_0000, 64'd0, 0, rd, er);
    chk("lit_ld_out_err", 64'(er), 64'd1);
    do_req(1'b1, SZ_D, 1'b0, 64'h300_0000, 64'h999, 0, rd, er);
    do_req(1'b0, SZ_D, 1'b0, 64'h200_FFF8, 64'd0, 0, rd, er);
    chk("lit_top_dword_ok", 64'(er), 64'd0);
    do_req(1'b0, SZ_D, 1'b0, 64'h201_0000, 64'd0, 0, rd, er);
    chk("lit_end_err", 64'(er), 64'd1);
    do_req(1'b0, SZ_D, 1'b0, 64'h1FF_FFF8, 64'd0, 0, rd, er);
    do_req(1'b0, SZ_D, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, rd, er);
    do_req(1'b0, SZ_W, 1'b0, 64'h200_4006, 64'd0, 0, rd, er);

    // mtime half store, then byte loads signed and unsigned
    do_req(1'b1, SZ_H, 1'b0, 64'h200_BFFA, 64'hFFFF_BEEF, 0, rd, er);
    chk("lit_sh_merge", last_wdata, 64'h0000_0000_BEEF_0000);
    do_req(1'b0, SZ_D, 1'b0, 64'h200_BFF8, 64'd0, 0, rd, er);
    chk("lit_ld_mtime", rd, 64'h0000_0000_BEEF_0000);
    do_req(1'b0, SZ_B, 1'b0, 64'h200_BFFB, 64'd0, 0, rd, er);
    chk("lit_lb", rd, 64'hFFFF_FFFF_FFFF_FFBE);
    do_req(1'b0, SZ_B, 1'b1, 64'h200_BFFB, 64'd0, 0, rd, er);
    chk("lit_lbu", rd, 64'h0000_0000_0000_00BE);
    do_req(1'b0, SZ_H, 1'b0, 64'h200_BFFA, 64'd0, 0, rd, er);
    chk("lit_lh", rd, 64'hFFFF_FFFF_FFFF_BEEF);

    // pass-through register in the window
    do_req(1'b1, SZ_W, 1'b0, 64'h200_0014, 64'hDEAD_BEEF, 0, rd, er);
    chk("lit_sw_pass_wdata", last_wdata, 64'hDEAD_BEEF_0000_0000);
    chk("lit_sw_pass_err", 64'(er), 64'd0);
    do_req(1'b0, SZ_W, 1'b1, 64'h200_0014, 64'd0, 0, rd, er);

    // back-pressured response, then reset during RD of the next load
    do_req(1'b0, SZ_D, 1'b0, 64'h200_4000, 64'd0, 3, rd, er);
    chk("lit_ld_held", rd, 64'h8000_0000_0000_0000);
    do_reset_in_rd(64'h200_4000);
    do_req(1'b0, SZ_D, 1'b0, 64'h200_4000, 64'd0, 0, rd, er);
    chk("lit_ld_after_rst", rd, 64'h8000_0000_0000_0000);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    fail("global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clint_mmio_bridge.md
# clint_mmio_bridge

MEM-stage initiator for the core-local interruptor (CLINT) timer registers. It accepts one load or store per handshake from the MEM stage and decodes the CLINT address window. It converts byte, half, word and dword accesses into the 64-bit-only read/write strobes the CLINT responder understands, using read-modify-write for sub-dword stores. It returns aligned and extended load data, or an error, on a valid/ready response channel.

## Interface
Parameters:
- CLINT_BASE, 64'h200_0000, first byte of the CLINT window
- CLINT_SIZE, 64'h1_0000, window size in bytes

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  MEM request valid
- req_ready  out  1  bridge can accept a request
- req_addr  in  64  byte address
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  MEM accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or outside window
- clint_addr  out  64  dword-aligned address to CLINT
- clint_wr_data  out  64  full 64-bit write value
- clint_wen  out  1  CLINT write strobe
- clint_ren  out  1  CLINT read strobe
- clint_rd_data  in  64  CLINT read data, combinational from clint_addr/clint_ren

## Operation
- FSM states: IDLE, RD, WR, RESP. Reset state is IDLE.
- req_ready = (state==IDLE) & rst_n. A request is accepted on the edge where req_valid & req_ready are both high. Address, size, unsigned flag and wdata are registered at acceptance.
- Error check: error if req_addr is not in [CLINT_BASE, CLINT_BASE+CLINT_SIZE) or is not aligned to 2^req_size.
  - Error requests go IDLE→RESP with resp_err=1 and resp_rdata=0.
  - No clint_ren or clint_wen is issued.
- Loads: IDLE→RD→RESP.
  - In RD: clint_ren=1 and clint_addr={addr[63:3],3'b0}.
  - On the RD edge, clint_rd_data is shifted right by addr[2:0]*8, truncated to size, then sign- or zero-extended into resp_rdata. Dword loads ignore req_unsigned.
- Dword stores: IDLE→WR→RESP. In WR: clint_wen=1 and clint_wr_data=wdata.
- Sub-dword stores: IDLE→RD→WR→RESP.
  - In RD, the old value is read.
  - On the RD edge, the low size bytes of wdata are merged into byte lane addr[2:0] of the old value. The result is held for WR.
  - In WR, the merged value is written.
  - Untouched bytes take their value from the RD cycle. A one-tick mtime loss on sub-dword mtime stores is accepted behaviour.
- In-window addresses other than mtime/mtimecmp are passed through. The responder returns 0 and ignores the write. resp_err=0 for these.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready. On resp_valid & resp_ready, the FSM returns to IDLE. A new request is accepted no earlier than the following cycle.
- clint_wen and clint_ren are never high together. Each is high for exactly one cycle per access. Both are 0 outside RD/WR.
- clint_addr and clint_wr_data are 0 when no strobe is active.

## Timing
- Reset: while rst_n is low, all outputs read 0, including req_ready. On the edge, state becomes IDLE and the response registers clear.
- Reset mid-operation (RD/WR/RESP): transaction aborted. The next state is IDLE with no strobe after the reset edge. The response is lost and not replayed.
- Latency from acceptance edge to first resp_valid cycle:
  - load: 2 cycles
  - dword store: 2 cycles
  - sub-dword store: 3 cycles
  - error: 1 cycle
- Throughput: one transaction per latency+1 cycles when resp_ready is held high.
- Window upper bound is exclusive: CLINT_BASE+CLINT_SIZE-8 is valid for a dword; CLINT_BASE+CLINT_SIZE is an error. The bound comparison uses 65-bit arithmetic, so no wrap-around occurs.

## Structure
- Shared package clint_pkg holds:
  - ADDR_MTIME 64'h200_BFF8 and ADDR_MTIMECMP 64'h200_4000
  - default CLINT_BASE/CLINT_SIZE
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - FSM state enum
- One combinational sub-module, clint_lane_align, performs load extract/extend and store merge given the offset, size and unsigned flag. It is shared by the RD capture path.

## Test plan
- After reset, ld dword at 0x200_4000 → clint_ren pulses once with clint_addr 0x200_4000; resp_valid appears 2 cycles after acceptance with resp_rdata 0 and resp_err 0.
- sd 0x1234 at 0x200_4000, then ld → exactly one clint_wen cycle with wr_data 0x1234; the load returns 0x1234.
- mtimecmp=0x1122334455667788, then sb 0xAB at 0x200_4003 → one ren cycle, then one wen cycle with wr_data 0x11223344AB667788.
- mtimecmp=0x8000000000000000: lw at 0x200_4004 → 0xFFFFFFFF80000000; lwu → 0x0000000080000000.
- lh at 0x200_4001, and ld at 0x300_0000 → resp_err=1, rdata 0, no strobes, resp_valid 1 cycle after acceptance.
- resp_ready held low 3 cycles → resp_valid/rdata stable and req_ready 0. Then rst_n pulsed while in RD of the next load → IDLE, no clint_wen, resp_valid 0.
